// File: rtl/dbus_responder_pkg.sv
// Shared dbus types: request/response records, access size, byte strobe,
// and the responder state encoding.
package dbus_responder_pkg;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef logic [7:0] strobe_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        strobe_t     strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef enum logic [1:0] {
        DR_IDLE,
        DR_WAIT,
        DR_RESP
    } dresp_state_t;

endpackage

// File: rtl/dmem_array.sv
// 64-bit word array: combinational read port, byte-strobed synchronous write
// port. Deliberately has no reset so contents survive a bus reset.
module dmem_array
    import dbus_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] ridx_i,
    output logic [63:0]   rdata_o,
    input  logic          we_i,
    input  logic [AW-1:0] widx_i,
    input  strobe_t       strobe_i,
    input  logic [63:0]   wdata_i
);

    logic [63:0] mem_q [DEPTH];

    always_comb begin
        rdata_o = mem_q[ridx_i];
    end

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (strobe_i[i]) begin
                    mem_q[widx_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dbus_responder.sv
// Memory-side dbus endpoint: latches one request, waits LATENCY cycles,
// returns the old aligned word for one cycle and commits any byte-strobed store.
module dbus_responder
    import dbus_responder_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output logic       busy
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [3:0]  CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    dresp_state_t  state_q;
    logic [3:0]    cnt_q;
    logic [AW-1:0] idx_q;
    strobe_t       strobe_q;
    logic [63:0]   wdata_q;
    logic          ok_q;
    logic [63:0]   rdata_q;
    logic          busy_q;

    logic [AW-1:0] idx_d;
    logic [AW-1:0] ridx;
    logic [63:0]   mem_rdata;
    logic          mem_we;
    logic          unused_bits;

    assign idx_d       = dreq.addr[AW+2:3];
    assign unused_bits = ^{dreq.size, dreq.addr[63:AW+3], dreq.addr[2:0]};

    // The response word is captured on the edge entering RESP; with LATENCY==1
    // that is the accepting edge, so the read port must see the live index in IDLE.
    assign ridx   = (state_q == DR_IDLE) ? idx_d : idx_q;
    assign mem_we = (state_q == DR_RESP);

    dmem_array #(
        .DEPTH(DEPTH)
    ) u_mem (
        .clk     (clk),
        .ridx_i  (ridx),
        .rdata_o (mem_rdata),
        .we_i    (mem_we),
        .widx_i  (idx_q),
        .strobe_i(strobe_q),
        .wdata_i (wdata_q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= DR_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            strobe_q <= '0;
            wdata_q  <= '0;
            ok_q     <= 1'b0;
            rdata_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                DR_IDLE: begin
                    if (dreq.valid) begin
                        idx_q    <= idx_d;
                        strobe_q <= dreq.strobe;
                        wdata_q  <= dreq.data;
                        busy_q   <= 1'b1;
                        if (LATENCY == 1) begin
                            state_q <= DR_RESP;
                            ok_q    <= 1'b1;
                            rdata_q <= mem_rdata;
                        end else begin
                            state_q <= DR_WAIT;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                DR_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= DR_RESP;
                        ok_q    <= 1'b1;
                        rdata_q <= mem_rdata;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DR_RESP: begin
                    state_q <= DR_IDLE;
                    ok_q    <= 1'b0;
                    rdata_q <= '0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= DR_IDLE;
            endcase
        end
    end

    always_comb begin
        dresp.addr_ok = ok_q;
        dresp.data_ok = ok_q;
        dresp.data    = rdata_q;
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_dbus_responder.sv
// Bench for dbus_responder: three instances (LATENCY 2/1/3) checked against a
// word-array reference model, directed vectors and random transactions.
module tb_dbus_responder;
    import dbus_responder_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    dbus_req_t  req [3];
    dbus_resp_t rsp [3];
    logic       bsy [3];

    int checks = 0;
    int errors = 0;

    int unsigned depth [3] = '{1024, 16, 16};
    int          lat   [3] = '{2, 1, 3};
    logic [63:0] mem_m [3][1024];

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  strb;
        logic [63:0] wdata;
        logic [63:0] exp;
    } vec_t;

    vec_t vt [6];

    always #5 clk = ~clk;

    dbus_responder #(.DEPTH(1024), .LATENCY(2)) dut_l2 (
        .clk(clk), .reset(reset), .dreq(req[0]), .dresp(rsp[0]), .busy(bsy[0]));
    dbus_responder #(.DEPTH(16), .LATENCY(1)) dut_l1 (
        .clk(clk), .reset(reset), .dreq(req[1]), .dresp(rsp[1]), .busy(bsy[1]));
    dbus_responder #(.DEPTH(16), .LATENCY(3)) dut_l3 (
        .clk(clk), .reset(reset), .dreq(req[2]), .dresp(rsp[2]), .busy(bsy[2]));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int widx(input int d, input logic [63:0] addr);
        return int'((addr >> 3) % 64'(depth[d]));
    endfunction

    // One request on instance d; drop>0 lowers valid at that cycle count.
    task automatic txn(input int d, input logic [63:0] addr, input logic [7:0] strb,
                       input logic [63:0] wdata, input bit use_exp, input logic [63:0] exp,
                       input int drop, input string nm);
        int          k;
        bit          seen;
        bit          busy_ok;
        logic [63:0] expd;
        int          ix;
        ix      = widx(d, addr);
        expd    = use_exp ? exp : mem_m[d][ix];
        @(negedge clk);
        req[d].valid  = 1'b1;
        req[d].addr   = addr;
        req[d].size   = msize_t'($urandom_range(0, 3));
        req[d].strobe = strb;
        req[d].data   = wdata;
        k       = 0;
        seen    = 1'b0;
        busy_ok = 1'b1;
        while (!seen && k < 20) begin
            @(negedge clk);
            k++;
            if (drop != 0 && k == drop) req[d].valid = 1'b0;
            if (rsp[d].data_ok) seen = 1'b1;
            else if (bsy[d] !== 1'b1) busy_ok = 1'b0;
        end
        chk({nm, "_latency"}, 64'(k), 64'(lat[d]));
        chk({nm, "_busy_wait"}, 64'(busy_ok), 64'd1);
        chk({nm, "_addr_ok"}, 64'(rsp[d].addr_ok), 64'd1);
        chk({nm, "_data"}, rsp[d].data, expd);
        if (seen) begin
            for (int i = 0; i < 8; i++)
                if (strb[i]) mem_m[d][ix][8*i +: 8] = wdata[8*i +: 8];
        end
        req[d].valid = 1'b0;
        @(negedge clk);
        chk({nm, "_after_flags"}, 64'({rsp[d].addr_ok, rsp[d].data_ok, bsy[d]}), 64'd0);
        chk({nm, "_after_data"}, rsp[d].data, 64'd0);
    endtask

    initial begin
        int          k;
        int          gap;
        bit          busy_low;
        logic [63:0] a;
        logic [7:0]  s;

        vt[0] = '{64'h10,   8'hFF, 64'h1122334455667788, 64'h0};
        vt[1] = '{64'h10,   8'h00, 64'h0,                64'h1122334455667788};
        vt[2] = '{64'h13,   8'h08, 64'h00000000AA000000, 64'h1122334455667788};
        vt[3] = '{64'h10,   8'h00, 64'h0,                64'h11223344AA667788};
        vt[4] = '{64'h2000, 8'hFF, 64'hCAFEF00DDEADBEEF, 64'h0};
        vt[5] = '{64'h0,    8'h00, 64'h0,                64'hCAFEF00DDEADBEEF};

        for (int d = 0; d < 3; d++) begin
            req[d] = '0;
            for (int i = 0; i < 1024; i++) mem_m[d][i] = '0;
        end

        reset = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset_flags%0d", d), 64'({rsp[d].addr_ok, rsp[d].data_ok, bsy[d]}), 64'd0);
            chk($sformatf("reset_data%0d", d), rsp[d].data, 64'd0);
        end
        reset = 1'b1;

        for (int i = 0; i < 6; i++)
            txn(0, vt[i].addr, vt[i].strb, vt[i].wdata, 1'b1, vt[i].exp, 0, $sformatf("vec%0d", i));

        // Back-to-back loads with valid held high.
        @(negedge clk);
        req[0].valid  = 1'b1;
        req[0].addr   = 64'h10;
        req[0].strobe = 8'h00;
        k = 0;
        while (rsp[0].data_ok !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("b2b_first_latency", 64'(k), 64'd2);
        chk("b2b_first_data", rsp[0].data, 64'h11223344AA667788);
        req[0].addr = 64'h18;
        gap = 0;
        busy_low = 1'b0;
        do begin
            @(negedge clk);
            gap++;
            if (bsy[0] === 1'b0) busy_low = 1'b1;
        end while (rsp[0].data_ok !== 1'b1 && gap < 20);
        chk("b2b_gap", 64'(gap), 64'd3);
        chk("b2b_busy_low_between", 64'(busy_low), 64'd1);
        chk("b2b_second_data", rsp[0].data, mem_m[0][3]);
        req[0].valid = 1'b0;
        @(negedge clk);

        // Reset while the store to 0x20 is in WAIT.
        @(negedge clk);
        req[0].valid  = 1'b1;
        req[0].addr   = 64'h20;
        req[0].strobe = 8'hFF;
        req[0].data   = 64'h5A5A5A5A5A5A5A5A;
        @(negedge clk);
        chk("rst_wait_busy_before", 64'(bsy[0]), 64'd1);
        reset = 1'b0;
        #1;
        chk("rst_wait_busy", 64'(bsy[0]), 64'd0);
        chk("rst_wait_data_ok", 64'(rsp[0].data_ok), 64'd0);
        req[0].valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        k = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp[0].data_ok !== 1'b0) k++;
        end
        chk("rst_no_data_ok", 64'(k), 64'd0);
        txn(0, 64'h20, 8'h00, 64'h0, 1'b1, 64'h0, 0, "rst_store_dropped");

        txn(1, 64'h40, 8'hFF, 64'h0123456789ABCDEF, 1'b1, 64'h0, 0, "l1_store");
        txn(1, 64'h40, 8'h00, 64'h0, 1'b1, 64'h0123456789ABCDEF, 0, "l1_load");
        txn(2, 64'h48, 8'hFF, 64'hFEDCBA9876543210, 1'b1, 64'h0, 1, "l3_drop");
        txn(2, 64'h48, 8'h00, 64'h0, 1'b1, 64'hFEDCBA9876543210, 0, "l3_load");

        for (int n = 0; n < 60; n++) begin
            int d;
            d = n % 3;
            a = (d == 0) ? 64'($urandom_range(0, 32'h3FFF)) : 64'($urandom_range(0, 32'hFF));
            s = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            txn(d, a, s, {$urandom, $urandom}, 1'b0, 64'h0, 0, $sformatf("rnd%0d_d%0d", n, d));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
